// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 keyboard receiver, scan-code decoder and make-code FIFO
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   rd         bus read strobe (level); one pop per rising edge
//   ps2kb_key  {valid, ext, scancode[7:0]} of the FIFO head, zero when empty
//   overflow   sticky flag: a key was dropped because the FIFO was full
//   frame_err  one-cycle pulse on start/stop/parity error or receive timeout
module ps2_key_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [9:0] ps2kb_key,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // ------------------------------------------------------------------
    // Pin synchronisers. Clock stages reset to 1 (bus idle level) so that
    // leaving reset never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic clk_s1_q, clk_sync_q, clk_hist_q;
    logic dat_s1_q, dat_sync_q;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_sync_q <= clk_s1_q;
            clk_hist_q <= clk_sync_q;
            dat_s1_q   <= ps2_data;
            dat_sync_q <= dat_s1_q;
        end
    end

    assign fall = clk_hist_q & ~clk_sync_q;

    // ------------------------------------------------------------------
    // Frame receiver. shift_q[i] holds frame bit i for i = 0..9; the stop
    // bit is checked straight from the synced pin on the final fall.
    // ------------------------------------------------------------------
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_rdy_q, byte_rdy_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;
    logic          frame_ok;

    // Odd parity: XOR over data bits and parity bit must be 1.
    assign frame_ok = ~shift_q[0] & dat_sync_q & (^shift_q[9:1]);

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        byte_rdy_d  = 1'b0;
        byte_d      = byte_q;
        frame_err_d = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (frame_ok) begin
                    byte_rdy_d = 1'b1;
                    byte_d     = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d[bit_cnt_q] = dat_sync_q;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Abort on the cycle the idle count would reach TIMEOUT_CYC.
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d   = 4'd0;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            byte_rdy_q  <= 1'b0;
            byte_q      <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            byte_rdy_q  <= byte_rdy_d;
            byte_q      <= byte_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Scan-code decoder: tracks E0 / F0 prefixes, emits make codes only.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_NORM   = 2'd0,
        S_EXT    = 2'd1,
        S_BRK    = 2'd2,
        S_EXTBRK = 2'd3
    } dec_state_t;

    dec_state_t state_q, state_d;
    logic       push;
    logic [8:0] push_data;
    logic       code_ignored;

    // Controller responses / error codes that are never keys.
    always_comb begin
        case (byte_q)
            8'h00, 8'hAA, 8'hE1, 8'hEE,
            8'hFA, 8'hFE, 8'hFF: code_ignored = 1'b1;
            default:             code_ignored = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_NORM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_rdy_q) begin
            case (state_q)
                S_NORM: begin
                    if (byte_q == 8'hE0)      state_d = S_EXT;
                    else if (byte_q == 8'hF0) state_d = S_BRK;
                    else                      state_d = S_NORM;
                end
                S_EXT: begin
                    if (byte_q == 8'hF0)      state_d = S_EXTBRK;
                    else if (byte_q == 8'hE0) state_d = S_EXT;
                    else                      state_d = S_NORM;
                end
                S_BRK:    state_d = S_NORM;
                S_EXTBRK: state_d = S_NORM;
                default:  state_d = S_NORM;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        push_data = {1'b0, byte_q};
        if (byte_rdy_q) begin
            case (state_q)
                S_NORM: begin
                    push      = (byte_q != 8'hE0) && (byte_q != 8'hF0) && !code_ignored;
                    push_data = {1'b0, byte_q};
                end
                S_EXT: begin
                    push      = (byte_q != 8'hE0) && (byte_q != 8'hF0);
                    push_data = {1'b1, byte_q};
                end
                default: begin
                    push      = 1'b0;
                    push_data = {1'b0, byte_q};
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key FIFO. Pointers carry a wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic          rd_q;
    logic          overflow_q;
    logic          empty, full, rd_rise, pop, wr_en;

    assign empty   = (head_q == tail_q);
    assign full    = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign rd_rise = rd & ~rd_q;
    assign pop     = rd_rise & ~empty;
    // When full, a same-cycle pop frees the slot the push writes into.
    assign wr_en   = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[tail_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            rd_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_q <= rd;
            if (wr_en) tail_q <= tail_q + PW'(1);
            if (pop)   head_q <= head_q + PW'(1);
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign ps2kb_key = empty ? 10'h000 : {1'b1, mem_q[head_q[AW-1:0]]};

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - directed self-checking bench for ps2_key_fifo
module tb_ps2_key_fifo;

    localparam int DEPTH = 8;
    localparam int TO    = 10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd = 1'b0;
    logic [9:0] ps2kb_key;
    logic       overflow;
    logic       frame_err;

    int vecs = 0;
    int miss = 0;
    int err_cnt = 0;
    int e0;

    ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd        (rd),
        .ps2kb_key (ps2kb_key),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && frame_err) err_cnt++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Drive the first nbits of a frame. With rd_stop set, rd rises in the
    // exact cycle the decoder pushes the received byte.
    task automatic send_bits(input logic [10:0] f, input int nbits, input bit rd_stop);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (2) @(negedge clk);
            ps2_clk = 1'b0;
            if (rd_stop && i == 10) begin
                repeat (3) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (2) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11, 1'b0);
    endtask

    task automatic rd_pulse();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("reset_key", 16'(ps2kb_key), 16'h000);
        check("reset_ovf", 16'(overflow), 16'h0);
        check("reset_ferr", 16'(frame_err), 16'h0);

        // Make code W
        send(8'h1D);
        check("w_key", 16'(ps2kb_key), 16'h21D);
        check("w_noerr", 16'(err_cnt), 16'd0);
        rd_pulse();
        check("w_pop", 16'(ps2kb_key), 16'h000);

        // Extended up arrow press and release
        send(8'hE0); send(8'h75);
        check("up_key", 16'(ps2kb_key), 16'h375);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_rel", 16'(ps2kb_key), 16'h375);
        rd_pulse();
        check("up_one", 16'(ps2kb_key), 16'h000);
        send(8'h1B);
        check("dec_norm", 16'(ps2kb_key), 16'h21B);
        rd_pulse();
        check("dec_pop", 16'(ps2kb_key), 16'h000);

        // Break suppression
        send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1C);
        check("brk_h0", 16'(ps2kb_key), 16'h21D);
        rd_pulse();
        check("brk_h1", 16'(ps2kb_key), 16'h21C);
        rd_pulse();
        check("brk_empty", 16'(ps2kb_key), 16'h000);
        rd_pulse();
        check("brk_empty2", 16'(ps2kb_key), 16'h000);

        // Parity error
        e0 = err_cnt;
        send_bits(mk_frame(8'h1D, 1'b1), 11, 1'b0);
        check("par_err1", 16'(err_cnt - e0), 16'd1);
        check("par_empty", 16'(ps2kb_key), 16'h000);
        send(8'h1B);
        check("par_recover", 16'(ps2kb_key), 16'h21B);
        check("par_noerr", 16'(err_cnt - e0), 16'd1);
        rd_pulse();

        // Overflow: nine codes into an eight-deep FIFO
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
        check("ovf_set", 16'(overflow), 16'h1);
        check("ovf_head", 16'(ps2kb_key), 16'h215);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), 16'(ps2kb_key), 16'h215 + 16'(i));
            rd_pulse();
        end
        check("ovf_lost", 16'(ps2kb_key), 16'h000);
        check("ovf_sticky", 16'(overflow), 16'h1);

        // Push and pop in the same cycle while full
        do_reset();
        check("ovf_rst", 16'(overflow), 16'h0);
        for (int i = 0; i < 8; i++) send(8'h15 + 8'(i));
        check("full_noovf", 16'(overflow), 16'h0);
        send_bits(mk_frame(8'h1D, 1'b0), 11, 1'b1);
        check("pp_noovf", 16'(overflow), 16'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_drain%0d", i), 16'(ps2kb_key), 16'h216 + 16'(i));
            rd_pulse();
        end
        check("pp_empty", 16'(ps2kb_key), 16'h000);

        // Timeout on a partial frame, then recovery and rd level behaviour
        e0 = err_cnt;
        send_bits(mk_frame(8'h24, 1'b0), 5, 1'b0);
        check("to_wait", 16'(err_cnt - e0), 16'd0);
        repeat (TO + 2) @(negedge clk);
        check("to_err", 16'(err_cnt - e0), 16'd1);
        send(8'h24);
        check("to_recover", 16'(ps2kb_key), 16'h224);
        send(8'h2B);
        check("to_head", 16'(ps2kb_key), 16'h224);
        rd = 1'b1;
        repeat (5) @(negedge clk);
        check("rd_level", 16'(ps2kb_key), 16'h22B);
        rd = 1'b0;
        @(negedge clk);
        rd_pulse();
        check("rd_final", 16'(ps2kb_key), 16'h000);
        check("to_err_once", 16'(err_cnt - e0), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Upstream keyboard front-end for the 2048 memory-mapped IO bus.
- Receives PS/2 scan-code frames and decodes E0 (extended) and F0 (break) prefixes.
- Queues make codes only in a small FIFO.
- Presents the queue head as the 10-bit ps2kb_key word, which the bus returns to the CPU on reads of the 0xD region. The FIFO pops once per read access.

Parameters:
- FIFO_DEPTH, 8: number of queued keys; must be a power of two, ≥2.
- TIMEOUT_CYC, 10000: clk cycles without a PS/2 falling edge mid-frame before the partial frame is aborted.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
- ps2_data  input  1  raw PS/2 data pin (asynchronous)
- rd  input  1  read strobe from the bus decoder; level, may stay high for several cycles per access
- ps2kb_key  output  10  {valid, ext, scancode[7:0]} of the FIFO head; all zero when empty
- overflow  output  1  sticky; a key was dropped because the FIFO was full
- frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error

Behaviour:
- One clock. Reset is synchronous and active-high; clock and reset ports are clk and rst.
- Reset state: ps2kb_key=0, overflow=0, frame_err=0, FIFO empty, bit counter 0, decoder in NORM, timeout counter 0, rd history 0. Reset mid-frame discards the partial frame.
- Input sync: 2-FF synchronisers on both pins, plus one history FF on the clock. fall = clk_hist & ~clk_sync. Data is sampled from the synced data pin in the fall cycle.
- Receiver, bit counter 0..10, 11-bit frame:
  - Bit 0 is start (0), bits 1..8 are data LSB first, bit 9 is parity (odd over data+parity), bit 10 is stop (1).
  - On the fall for bit 10 the counter returns to 0 and the frame is checked in the same cycle.
  - Good frame: byte_rdy pulses one cycle later, together with the byte.
  - Bad start, stop or parity: frame_err pulses one cycle later and the byte is dropped.
- Timeout: while the bit counter ≠0, the counter increments each cycle without a fall and clears on every fall. When it reaches TIMEOUT_CYC: bit counter←0, timeout counter←0, frame_err pulses one cycle.
- Decoder FSM, acting on byte_rdy:
  - NORM: E0→EXT; F0→BRK; 00, AA, E1, EE, FA, FE, FF are discarded, stay NORM; any other code pushes {ext=0, code}, stay NORM.
  - EXT: F0→EXTBRK; E0 stays EXT; any other code pushes {ext=1, code}→NORM.
  - BRK: any byte is discarded →NORM (releases are never queued).
  - EXTBRK: any byte is discarded →NORM.
- Push timing: the push happens in the byte_rdy cycle. ps2kb_key shows the new entry on the following edge if the FIFO was empty.
- Pop: rd_rise = rd & ~rd_q, where rd_q is registered every cycle.
  - The pop occurs on the edge where rd_rise=1 and the FIFO is non-empty.
  - The value presented during the rd_rise cycle is the entry consumed, because the bus latches it on that same edge.
  - rd held high pops exactly once. rd_rise while empty has no effect.
- FIFO: registered head and tail pointers, log2(FIFO_DEPTH)+1 bits with a wrap bit. empty = pointers equal; full = indices equal and wrap bits differ.
  - Simultaneous push and pop: both happen; occupancy unchanged, including when full (no overflow).
  - Push while full without a pop: the entry is dropped and overflow←1 until rst.
- ps2kb_key: {~empty, mem[head]} when non-empty, else 10'h000. It is driven from registered state only, with no combinational path from rd.

Test Plan:
- Make code "W" (1D): send frame 1D with parity 1 → ps2kb_key=10'h21D within 8 cycles of the synced stop fall; frame_err stays 0. Then one rd pulse → ps2kb_key=10'h000.
- Extended up arrow (E0 75), then release (E0 F0 75) → exactly one entry, 10'h375. The release adds nothing; the decoder ends in NORM.
- Break suppression (1D, F0 1D, 1C) → the FIFO holds 10'h21D then 10'h21C. Two rd pulses drain it; a third rd pulse leaves 10'h000.
- Parity error: frame 1D with parity 0 → frame_err high for exactly 1 cycle, FIFO empty. A following good 1B frame → 10'h21B.
- Overflow with FIFO_DEPTH=8: send 9 codes 15,16,…,1D with no reads → overflow=1, head 10'h215. Draining yields 15..1C; 1D is lost. Push and rd_rise in the same cycle when full → overflow does not set.
- Timeout and rd level: stop clocking after 5 bits, wait TIMEOUT_CYC+2 cycles → frame_err pulse, counter 0. A good 24 frame → 10'h224. Hold rd high for 5 cycles → exactly one pop.
